// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared types and constants for the instruction-memory loader.
// Contents: loader state encoding, bytes per instruction word, halt word (shared with the CPU halt decode).
package instruction_loader_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_PRESENT,
        ST_STROBE,
        ST_DONE
    } state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: control, UART byte stream and instruction-memory write port of the loader.
// Signals: i_load_start (start pulse), i_rx_data/i_rx_done (received byte + valid pulse),
//          o_instruction_address/o_instruction/o_flag_write_intruc (memory write port),
//          o_busy/o_load_done/o_overflow/o_rx_drop (status).
// Modports: master = the loader, slave = debug unit / UART / memory side.
interface instruction_loader_if #(
    parameter int SIZE_ADDR_PC = 32,
    parameter int SIZE_BYTE    = 8
);
    logic                    i_load_start;
    logic [SIZE_BYTE-1:0]    i_rx_data;
    logic                    i_rx_done;
    logic [SIZE_ADDR_PC-1:0] o_instruction_address;
    logic [SIZE_ADDR_PC-1:0] o_instruction;
    logic                    o_flag_write_intruc;
    logic                    o_busy;
    logic                    o_load_done;
    logic                    o_overflow;
    logic                    o_rx_drop;
    modport master (
        input  i_load_start, i_rx_data, i_rx_done,
        output o_instruction_address, o_instruction, o_flag_write_intruc,
        output o_busy, o_load_done, o_overflow, o_rx_drop
    );
    modport slave (
        output i_load_start, i_rx_data, i_rx_done,
        input  o_instruction_address, o_instruction, o_flag_write_intruc,
        input  o_busy, o_load_done, o_overflow, o_rx_drop
    );
endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// instruction_loader_byte_assembler: packs received bytes MSB first into instruction words.
// Ports: i_clk, i_reset (async, active-low), i_clear (restart count), i_enable (accept bytes),
//        i_rx_data/i_rx_done (byte stream), o_word_next (word including the byte now arriving),
//        o_word_ready (pulse: the byte now arriving completes a word).
module instruction_loader_byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int SIZE_BYTE = 8,
    parameter int SIZE_WORD = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [SIZE_BYTE-1:0] i_rx_data,
    input  logic                 i_rx_done,
    output logic [SIZE_WORD-1:0] o_word_next,
    output logic                 o_word_ready
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    // Only the bytes already received are stored; the final byte completes the word
    // combinationally so the loader can register the full word on the same edge.
    logic [SIZE_WORD-SIZE_BYTE-1:0] r_shift;
    logic [1:0]                     r_count;
    logic                           w_take;
    assign w_take       = i_enable && i_rx_done;
    assign o_word_next  = {r_shift, i_rx_data};
    assign o_word_ready = w_take && r_count == LAST_BYTE;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_take) begin
            r_shift <= o_word_next[SIZE_WORD-SIZE_BYTE-1:0];
            r_count <= r_count + 2'd1;
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: writes UART-received instruction words to consecutive memory indices from 0.
// Ports: i_clk, i_reset (async, active-low), bus (instruction_loader_if.master):
//        start pulse and byte stream in; memory address/data/write strobe and status flags out.
// A load ends after the halt word is written or after TOTAL_SIZE words (overflow).
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int SIZE_ADDR_PC = 32,
    parameter int TOTAL_SIZE   = 256,
    parameter int SIZE_BYTE    = 8,
    parameter logic [SIZE_ADDR_PC-1:0] HALT_WORD = SIZE_ADDR_PC'(instruction_loader_pkg::HALT_WORD)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    instruction_loader_if.master bus
);
    localparam logic [SIZE_ADDR_PC-1:0] LAST_INDEX = SIZE_ADDR_PC'(TOTAL_SIZE - 1);
    state_t                  r_state;
    logic [SIZE_ADDR_PC-1:0] r_index;
    logic [SIZE_ADDR_PC-1:0] r_address;
    logic [SIZE_ADDR_PC-1:0] r_instruction;
    logic                    r_flag;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;
    logic                    r_rx_drop;
    logic                    w_start;
    logic                    w_word_ready;
    logic [SIZE_ADDR_PC-1:0] w_word_next;
    assign w_start = bus.i_load_start && (r_state == ST_IDLE || r_state == ST_DONE);
    instruction_loader_byte_assembler #(
        .SIZE_BYTE (SIZE_BYTE),
        .SIZE_WORD (SIZE_ADDR_PC)
    ) u_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_start),
        .i_enable     (r_state == ST_RECEIVE),
        .i_rx_data    (bus.i_rx_data),
        .i_rx_done    (bus.i_rx_done),
        .o_word_next  (w_word_next),
        .o_word_ready (w_word_ready)
    );
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_address     <= '0;
            r_instruction <= '0;
            r_flag        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_rx_drop     <= 1'b0;
        end else begin
            // Bytes arriving while a word is being written have nowhere to go.
            if (bus.i_rx_done && (r_state == ST_PRESENT || r_state == ST_STROBE))
                r_rx_drop <= 1'b1;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state    <= ST_RECEIVE;
                        r_index    <= '0;
                        r_overflow <= 1'b0;
                        r_rx_drop  <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    // Address and data are loaded on entry to PRESENT so they are
                    // stable for a full cycle before the strobe rises.
                    if (w_word_ready) begin
                        r_instruction <= w_word_next;
                        r_address     <= r_index;
                        r_state       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    r_flag  <= 1'b1;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    r_flag  <= 1'b0;
                    r_index <= r_index + 1'b1;
                    if (r_instruction == HALT_WORD || r_index == LAST_INDEX) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= r_instruction != HALT_WORD;
                    end else begin
                        r_state <= ST_RECEIVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.o_instruction_address = r_address;
    assign bus.o_instruction         = r_instruction;
    assign bus.o_flag_write_intruc   = r_flag;
    assign bus.o_busy                = r_busy;
    assign bus.o_load_done           = r_done;
    assign bus.o_overflow            = r_overflow;
    assign bus.o_rx_drop             = r_rx_drop;
endmodule
